// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and helpers for the pipeline hazard /
// sequencing controller.
//   - REG_IDX_WIDTH  : width of an architectural register index
//   - WAIT_CNT_WIDTH : width of the data-memory wait counter (timeout <= 255)
//   - pctl_state_e   : controller state encoding
//   - ctrl_t         : bundle of the pipeline control outputs
//   - ctrl_* helpers : canonical control patterns for each situation
package pipeline_ctrl_pkg;

  localparam int REG_IDX_WIDTH  = 5;
  localparam int WAIT_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    PCTL_RUN      = 2'd0,
    PCTL_MEM_WAIT = 2'd1,
    PCTL_HALT     = 2'd2,
    PCTL_ERROR    = 2'd3
  } pctl_state_e;

  typedef struct packed {
    logic dmem_req;
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_en;
  } ctrl_t;

  // Everything off: used in reset, HALT and ERROR.
  localparam ctrl_t CTRL_IDLE = '{
    dmem_req: 1'b0, pc_en: 1'b0, ifid_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0, pipe_en: 1'b0
  };

  // Full freeze while the data memory has not answered; the request stays up.
  localparam ctrl_t CTRL_FREEZE = '{
    dmem_req: 1'b1, pc_en: 1'b0, ifid_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0, pipe_en: 1'b0
  };

  // Halting instruction in WB: stop fetch/decode, let the back end retire it.
  function automatic ctrl_t ctrl_halt(input logic dmem_req);
    ctrl_t c;
    c            = CTRL_IDLE;
    c.dmem_req   = dmem_req;
    c.pipe_en    = 1'b1;
    return c;
  endfunction

  // Normal flow once memory is not blocking: redirect beats load-use,
  // which beats plain advance.
  function automatic ctrl_t ctrl_run_rules(input logic redirect,
                                           input logic load_use,
                                           input logic dmem_req);
    ctrl_t c;
    c.dmem_req   = dmem_req;
    c.pipe_en    = 1'b1;
    c.ifid_flush = 1'b0;
    c.idex_flush = 1'b0;
    c.pc_en      = 1'b1;
    c.ifid_en    = 1'b1;
    if (redirect) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end else begin
      c.idex_flush = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// pipeline_ctrl_hazard_detect: combinational load-use hazard comparator.
// Flags when the instruction in EX is a load whose destination (non-x0)
// is a source actually read by the instruction in ID.
//   idRs1_i, idRs2_i         : ID source register indices
//   idUsesRs1_i, idUsesRs2_i : ID instruction really reads rs1 / rs2
//   idexMemRead_i            : EX instruction is a load
//   idexRd_i                 : EX destination register
//   loadUse_o                : load-use hazard present this cycle
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_WIDTH-1:0] idRs1_i,
  input  logic [REG_IDX_WIDTH-1:0] idRs2_i,
  input  logic                     idUsesRs1_i,
  input  logic                     idUsesRs2_i,
  input  logic                     idexMemRead_i,
  input  logic [REG_IDX_WIDTH-1:0] idexRd_i,
  output logic                     loadUse_o
);

  logic rdNonZero_s;
  logic rs1Hit_s;
  logic rs2Hit_s;

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign rdNonZero_s = (idexRd_i != {REG_IDX_WIDTH{1'b0}});
  assign rs1Hit_s    = idUsesRs1_i & (idexRd_i == idRs1_i);
  assign rs2Hit_s    = idUsesRs2_i & (idexRd_i == idRs2_i);
  assign loadUse_o   = idexMemRead_i & rdNonZero_s & (rs1Hit_s | rs2Hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central hazard and sequencing controller of the 5-stage
// pipeline. Control outputs are combinational from the registered state and
// the current inputs; state, wait counter and performance counters are
// registered.
//   clk, reset (async, active-low)
//   idRs1/idRs2, idUsesRs1/idUsesRs2 : ID stage sources
//   idexMemRead, idexRd              : EX stage load info
//   exRedirect                       : taken branch / jump resolved in EX
//   exmemMemRead/exmemMemWrite       : MEM stage access
//   dmemReady                        : data memory completes this cycle
//   haltReq                          : ecall/ebreak reached WB
//   dmemReq, pcEn, ifidEn, ifidFlush, idexFlush, pipeEn : pipeline control
//   halted, busErr                   : terminal status
//   cycleCnt, stallCnt, flushCnt     : wrapping performance counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_IDX_WIDTH-1:0] idRs1,
  input  logic [REG_IDX_WIDTH-1:0] idRs2,
  input  logic                     idUsesRs1,
  input  logic                     idUsesRs2,
  input  logic                     idexMemRead,
  input  logic [REG_IDX_WIDTH-1:0] idexRd,
  input  logic                     exRedirect,
  input  logic                     exmemMemRead,
  input  logic                     exmemMemWrite,
  input  logic                     dmemReady,
  input  logic                     haltReq,
  output logic                     dmemReq,
  output logic                     pcEn,
  output logic                     ifidEn,
  output logic                     ifidFlush,
  output logic                     idexFlush,
  output logic                     pipeEn,
  output logic                     halted,
  output logic                     busErr,
  output logic [CNT_WIDTH-1:0]     cycleCnt,
  output logic [CNT_WIDTH-1:0]     stallCnt,
  output logic [CNT_WIDTH-1:0]     flushCnt
);

  localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_C = WAIT_CNT_WIDTH'(MEM_TIMEOUT);

  pctl_state_e               state_q;
  pctl_state_e               state_d;
  logic [WAIT_CNT_WIDTH-1:0] waitCnt_q;
  logic [WAIT_CNT_WIDTH-1:0] waitCnt_d;
  logic [CNT_WIDTH-1:0]      cycleCnt_q;
  logic [CNT_WIDTH-1:0]      stallCnt_q;
  logic [CNT_WIDTH-1:0]      flushCnt_q;

  ctrl_t ctrl_s;
  logic  memAcc_s;
  logic  loadUse_s;
  logic  stallInc_s;
  logic  flushInc_s;

  assign memAcc_s = exmemMemRead | exmemMemWrite;

  pipeline_ctrl_hazard_detect u_hazard_detect (
    .idRs1_i       (idRs1),
    .idRs2_i       (idRs2),
    .idUsesRs1_i   (idUsesRs1),
    .idUsesRs2_i   (idUsesRs2),
    .idexMemRead_i (idexMemRead),
    .idexRd_i      (idexRd),
    .loadUse_o     (loadUse_s)
  );

  // Next-state, wait counter, counter increments and control outputs.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    ctrl_s     = CTRL_IDLE;
    stallInc_s = 1'b0;
    flushInc_s = 1'b0;

    case (state_q)
      PCTL_RUN: begin
        if (haltReq) begin
          ctrl_s  = ctrl_halt(memAcc_s);
          state_d = PCTL_HALT;
        end else if (memAcc_s && !dmemReady) begin
          ctrl_s    = CTRL_FREEZE;
          state_d   = PCTL_MEM_WAIT;
          waitCnt_d = WAIT_CNT_WIDTH'(1);
        end else begin
          ctrl_s     = ctrl_run_rules(exRedirect, loadUse_s, memAcc_s);
          flushInc_s = exRedirect;
          // A redirect squashes the load-use instruction, so no stall then.
          stallInc_s = loadUse_s & ~exRedirect;
        end
      end

      PCTL_MEM_WAIT: begin
        // Every cycle spent here is a stall cycle, including the release
        // cycle; a load-use on that cycle does not add a second count.
        stallInc_s = 1'b1;
        if (dmemReady) begin
          // Stages were held, so any redirect/load-use seen now is the one
          // that was pending when the freeze began.
          waitCnt_d = {WAIT_CNT_WIDTH{1'b0}};
          if (haltReq) begin
            ctrl_s  = ctrl_halt(1'b1);
            state_d = PCTL_HALT;
          end else begin
            ctrl_s     = ctrl_run_rules(exRedirect, loadUse_s, 1'b1);
            flushInc_s = exRedirect;
            state_d    = PCTL_RUN;
          end
        end else if (waitCnt_q == TIMEOUT_C) begin
          ctrl_s  = CTRL_FREEZE;
          state_d = PCTL_ERROR;
        end else begin
          ctrl_s    = CTRL_FREEZE;
          waitCnt_d = waitCnt_q + WAIT_CNT_WIDTH'(1);
        end
      end

      PCTL_HALT: begin
        ctrl_s  = CTRL_IDLE;
        state_d = PCTL_HALT;
      end

      PCTL_ERROR: begin
        // Terminal until reset; haltReq is deliberately ignored.
        ctrl_s  = CTRL_IDLE;
        state_d = PCTL_ERROR;
      end

      default: begin
        ctrl_s  = CTRL_IDLE;
        state_d = PCTL_ERROR;
      end
    endcase
  end

  // State, wait counter and performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PCTL_RUN;
      waitCnt_q  <= {WAIT_CNT_WIDTH{1'b0}};
      cycleCnt_q <= {CNT_WIDTH{1'b0}};
      stallCnt_q <= {CNT_WIDTH{1'b0}};
      flushCnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      cycleCnt_q <= cycleCnt_q + CNT_WIDTH'(1);
      stallCnt_q <= stallCnt_q + CNT_WIDTH'(stallInc_s);
      flushCnt_q <= flushCnt_q + CNT_WIDTH'(flushInc_s);
    end
  end

  // While reset is held the state already reads RUN, so the enables must be
  // gated explicitly to reach their quiet values without waiting for a clock.
  assign dmemReq   = reset & ctrl_s.dmem_req;
  assign pcEn      = reset & ctrl_s.pc_en;
  assign ifidEn    = reset & ctrl_s.ifid_en;
  assign ifidFlush = reset & ctrl_s.ifid_flush;
  assign idexFlush = reset & ctrl_s.idex_flush;
  assign pipeEn    = reset & ctrl_s.pipe_en;

  assign halted    = (state_q == PCTL_HALT);
  assign busErr    = (state_q == PCTL_ERROR);

  assign cycleCnt  = cycleCnt_q;
  assign stallCnt  = stallCnt_q;
  assign flushCnt  = flushCnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (CNT_WIDTH=4, MEM_TIMEOUT=4):
// directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic [4:0] idRs1, idRs2, idexRd;
  logic       idUsesRs1, idUsesRs2, idexMemRead, exRedirect;
  logic       exmemMemRead, exmemMemWrite, dmemReady, haltReq;
  logic       dmemReq, pcEn, ifidEn, ifidFlush, idexFlush, pipeEn;
  logic       halted, busErr;
  logic [CW-1:0] cycleCnt, stallCnt, flushCnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit m_wait, m_halt, m_err;
  int m_waited, m_cyc, m_stl, m_fls;

  pipeline_ctrl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idexMemRead(idexMemRead), .idexRd(idexRd), .exRedirect(exRedirect),
    .exmemMemRead(exmemMemRead), .exmemMemWrite(exmemMemWrite),
    .dmemReady(dmemReady), .haltReq(haltReq),
    .dmemReq(dmemReq), .pcEn(pcEn), .ifidEn(ifidEn), .ifidFlush(ifidFlush),
    .idexFlush(idexFlush), .pipeEn(pipeEn), .halted(halted), .busErr(busErr),
    .cycleCnt(cycleCnt), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // {dmemReq, pcEn, ifidEn, ifidFlush, idexFlush, pipeEn}
  function automatic logic [5:0] ctrl_vec();
    return {dmemReq, pcEn, ifidEn, ifidFlush, idexFlush, pipeEn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    idRs1 = 5'd0; idRs2 = 5'd0; idexRd = 5'd0;
    idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; idexMemRead = 1'b0; exRedirect = 1'b0;
    exmemMemRead = 1'b0; exmemMemWrite = 1'b0; dmemReady = 1'b0; haltReq = 1'b0;
  endtask

  // Compare process: each falling edge, check DUT against the model, then
  // advance the model by the cycle the next rising edge will commit.
  initial begin
    bit lu, ma, rel;
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_wait = 0; m_halt = 0; m_err = 0;
        m_waited = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
        chk("rst_ctrl", 32'(ctrl_vec()), 32'd0);
        chk("rst_cnt", 32'({cycleCnt, stallCnt, flushCnt}), 32'd0);
        chk("rst_stat", 32'({halted, busErr}), 32'd0);
      end else begin
        chk("m_cycle", 32'(cycleCnt), 32'(m_cyc % 16));
        chk("m_stall", 32'(stallCnt), 32'(m_stl % 16));
        chk("m_flush", 32'(flushCnt), 32'(m_fls % 16));
        chk("m_halted", 32'(halted), 32'(m_halt));
        chk("m_buserr", 32'(busErr), 32'(m_err));

        ma = exmemMemRead || exmemMemWrite;
        lu = idexMemRead && (idexRd != 5'd0) &&
             ((idUsesRs1 && idexRd == idRs1) || (idUsesRs2 && idexRd == idRs2));
        e = 6'b000000;
        if (m_halt || m_err) begin
          e = 6'b000000;
        end else if (m_wait && !dmemReady) begin
          e = 6'b100000;
          m_stl++;
          if (m_waited == TO) m_err = 1;
          else m_waited++;
        end else begin
          rel = m_wait;
          if (rel) m_stl++;
          if (haltReq) begin
            e = {rel | ma, 5'b00001};
            m_halt = 1;
          end else if (!rel && ma && !dmemReady) begin
            e = 6'b100000;
            m_wait = 1;
            m_waited = 1;
          end else if (exRedirect) begin
            e = {rel | ma, 5'b11111};
            m_fls++;
          end else if (lu) begin
            e = {rel | ma, 5'b00011};
            if (!rel) m_stl++;
          end else begin
            e = {rel | ma, 5'b11001};
          end
          if (rel) begin
            m_wait = 0;
            m_waited = 0;
          end
        end
        chk("m_ctrl", 32'(ctrl_vec()), 32'(e));
        m_cyc++;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    idle_in();
    reset = 1'b0;
    #1;
    chk("reset_enables", 32'({pcEn, ifidEn, pipeEn, dmemReq}), 32'd0);
    chk("reset_counters", 32'({cycleCnt, stallCnt, flushCnt}), 32'd0);
    step(); step(); step();
    reset = 1'b1;

    // Load-use on rs2
    idexMemRead = 1'b1; idexRd = 5'd5; idRs2 = 5'd5; idUsesRs2 = 1'b1;
    #1;
    chk("lu_ctrl", 32'({pcEn, ifidEn, idexFlush, pipeEn}), 32'b0011);
    chk("lu_stall_before", 32'(stallCnt), 32'd0);
    step(); idle_in(); #1;
    chk("lu_stall_after", 32'(stallCnt), 32'd1);
    chk("lu_released", 32'({pcEn, ifidEn, idexFlush}), 32'b110);

    // Load into x0 is not a hazard
    idexMemRead = 1'b1; idexRd = 5'd0; idRs1 = 5'd0; idRs2 = 5'd0;
    idUsesRs1 = 1'b1; idUsesRs2 = 1'b1;
    #1;
    chk("x0_no_stall", 32'({pcEn, ifidEn, idexFlush}), 32'b110);
    step(); idle_in(); #1;
    chk("x0_stall_cnt", 32'(stallCnt), 32'd1);

    // Redirect together with a load-use match
    exRedirect = 1'b1; idexMemRead = 1'b1; idexRd = 5'd7; idRs1 = 5'd7; idUsesRs1 = 1'b1;
    #1;
    chk("redir_ctrl", 32'({pcEn, ifidFlush, idexFlush, pipeEn}), 32'b1111);
    step(); idle_in(); #1;
    chk("redir_stall", 32'(stallCnt), 32'd1);
    chk("redir_flush", 32'(flushCnt), 32'd1);

    // Memory wait: ready low for 3 cycles then high
    exmemMemRead = 1'b1; dmemReady = 1'b0;
    #1;
    chk("mw_freeze0", 32'(ctrl_vec()), 32'b100000);
    step(); #1;
    chk("mw_freeze1", 32'(ctrl_vec()), 32'b100000);
    step(); #1;
    chk("mw_freeze2", 32'(ctrl_vec()), 32'b100000);
    step(); dmemReady = 1'b1; #1;
    chk("mw_release", 32'(ctrl_vec()), 32'b111001);
    chk("mw_stall_mid", 32'(stallCnt), 32'd3);
    step(); idle_in(); #1;
    chk("mw_stall_done", 32'(stallCnt), 32'd4);
    chk("mw_run_again", 32'({pcEn, pipeEn}), 32'b11);

    // Async reset in the middle of a memory wait
    exmemMemRead = 1'b1; dmemReady = 1'b0;
    step(); #1;
    chk("ar_in_wait", 32'(ctrl_vec()), 32'b100000);
    reset = 1'b0; #1;
    chk("ar_immediate", 32'(ctrl_vec()), 32'd0);
    chk("ar_counters", 32'({cycleCnt, stallCnt, flushCnt}), 32'd0);
    step(); reset = 1'b1; idle_in(); #1;
    chk("ar_run", 32'({pcEn, ifidEn, pipeEn, dmemReq}), 32'b1110);

    // cycleCnt wrap 15 -> 0
    for (int i = 0; i < 15; i++) step();
    chk("wrap_15", 32'(cycleCnt), 32'd15);
    step();
    chk("wrap_0", 32'(cycleCnt), 32'd0);

    // Halt
    haltReq = 1'b1; #1;
    chk("halt_cycle", 32'({pcEn, ifidEn, pipeEn, halted}), 32'b0010);
    step(); haltReq = 1'b0; exmemMemRead = 1'b1; exRedirect = 1'b1; #1;
    chk("halted_flag", 32'(halted), 32'd1);
    chk("halted_ctrl", 32'(ctrl_vec()), 32'd0);
    step(); step(); step();
    chk("halt_cycle_cnt", 32'(cycleCnt), 32'd4);
    chk("halt_other_cnt", 32'({stallCnt, flushCnt}), 32'd0);

    // Timeout to bus error
    #1; reset = 1'b0;
    step(); reset = 1'b1; idle_in();
    exmemMemWrite = 1'b1; dmemReady = 1'b0; #1;
    chk("to_first", 32'({pipeEn, busErr}), 32'b00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_waiting", 32'(busErr), 32'd0);
    end
    step();
    chk("to_buserr", 32'(busErr), 32'd1);
    chk("to_ctrl", 32'(ctrl_vec()), 32'd0);
    haltReq = 1'b1;
    step();
    chk("to_ignore_halt", 32'({halted, busErr}), 32'b01);
    chk("to_stall_cnt", 32'(stallCnt), 32'd4);

    // Randomized traffic
    #1; reset = 1'b0;
    step(); reset = 1'b1; idle_in();
    for (int n = 0; n < 4000; n++) begin
      step();
      reset         = 1'b1;
      idRs1         = 5'($urandom_range(0, 3));
      idRs2         = 5'($urandom_range(0, 3));
      idexRd        = 5'($urandom_range(0, 3));
      idUsesRs1     = 1'($urandom_range(0, 1));
      idUsesRs2     = 1'($urandom_range(0, 1));
      idexMemRead   = 1'($urandom_range(0, 1));
      exRedirect    = ($urandom_range(0, 5) == 0);
      exmemMemRead  = ($urandom_range(0, 3) == 0);
      exmemMemWrite = ($urandom_range(0, 3) == 0);
      dmemReady     = ($urandom_range(0, 9) < 6);
      haltReq       = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 69) == 0) begin
        #2;
        reset = 1'b0;
      end
    end
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
